// File: rtl/spiram_pkg.sv
// Shared types, constants and lane helpers for the SPI RAM port arbiter.
package spiram_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_W     = 2;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned RAM_ADDR_W = 16;
  localparam int unsigned PORTS      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic op_t;
  localparam op_t OP_RD = 1'b0;
  localparam op_t OP_WR = 1'b1;

  // Request payload captured per port (address is held separately, its width is a parameter).
  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  wmask;
  } req_t;

  // Result of a lane search: valid=0 means no lane left.
  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
  } lane_pick_t;

  // Lowest set lane of a byte mask.
  function automatic lane_pick_t lowest_lane(input logic [LANES-1:0] mask);
    lane_pick_t pick;
    pick = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        pick.valid = 1'b1;
        pick.lane  = LANE_W'(i);
      end
    end
    return pick;
  endfunction

  // Mask selecting the lanes strictly above the given lane.
  function automatic logic [LANES-1:0] lanes_above(input logic [LANE_W-1:0] lane);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      m[i] = (i > int'(lane));
    end
    return m;
  endfunction

endpackage

// File: rtl/spiram_rr_arbiter.sv
// Two-requester round-robin arbiter; grant is combinational, pointer moves on grant.
module spiram_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  // Port that received the most recent grant; reset value makes port 0 win a tie.
  logic last;

  // One requester wins outright; on a tie the port that was not granted last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

  // Pointer update when the grant is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (grant_en && (|req)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/spiram_port_arbiter.sv
// Shares one SPI RAM controller between a CPU port (0) and an aux/DMA port (1).
// Masked 32-bit writes become ascending single-byte SPI writes; reads are one 32-bit SPI read.
module spiram_port_arbiter
  import spiram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_rd,
  input  logic                  p0_wr,
  input  logic [ADDR_W-1:0]     p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic [LANES-1:0]      p0_wmask,
  output logic                  p0_busy,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_W-1:0]     p0_rdata,
  input  logic                  p1_rd,
  input  logic                  p1_wr,
  input  logic [ADDR_W-1:0]     p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  input  logic [LANES-1:0]      p1_wmask,
  output logic                  p1_busy,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_W-1:0]     p1_rdata,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_rbusy,
  input  logic                  ram_wbusy
);

  localparam int unsigned      TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  // Per-port request inputs gathered into vectors.
  logic [PORTS-1:0] rd_in;
  logic [PORTS-1:0] wr_in;
  logic [PORTS-1:0] cap;

  // Capture latches and per-port status.
  req_t              req_q  [PORTS];
  logic [ADDR_W-1:0] addr_q [PORTS];
  logic [DATA_W-1:0] rdata_q[PORTS];
  logic [PORTS-1:0]  pend;
  logic [PORTS-1:0]  busy_q;
  logic [PORTS-1:0]  ack_q;
  logic [PORTS-1:0]  err_q;

  // Sequencer state.
  state_t            state;
  state_t            state_n;
  logic              cur;
  logic              nxt_port;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_n;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_n;
  logic              err_flag;
  logic              err_n;
  logic              grant_en;
  logic              cap_rdata;
  logic [1:0]        gnt;
  lane_pick_t        pick;
  req_t              req_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic              ram_busy;
  logic              issue_n;
  logic              done_n;

  assign rd_in    = {p1_rd, p0_rd};
  assign wr_in    = {p1_wr, p0_wr};
  assign cap      = ~busy_q & (rd_in | wr_in);
  assign ram_busy = ram_rbusy | ram_wbusy;

  // The port being served next cycle: the arbiter winner in IDLE, otherwise the current one.
  assign nxt_port = (state == IDLE && (|pend)) ? gnt[1] : cur;
  assign req_sel  = req_q[nxt_port];
  assign addr_sel = addr_q[nxt_port];
  assign issue_n  = (state_n == ISSUE);
  assign done_n   = (state_n == DONE);

  assign p0_busy  = busy_q[0];
  assign p1_busy  = busy_q[1];
  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_err   = err_q[0];
  assign p1_err   = err_q[1];
  assign p0_rdata = rdata_q[0];
  assign p1_rdata = rdata_q[1];

  spiram_rr_arbiter u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (pend),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // Request capture: one op per idle port; read wins over a simultaneous write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PORTS); i++) begin
        req_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (cap[0]) begin
        req_q[0].op    <= p0_rd ? OP_RD : OP_WR;
        req_q[0].wdata <= p0_wdata;
        req_q[0].wmask <= p0_wmask;
        addr_q[0]      <= p0_addr;
      end
      if (cap[1]) begin
        req_q[1].op    <= p1_rd ? OP_RD : OP_WR;
        req_q[1].wdata <= p1_wdata;
        req_q[1].wmask <= p1_wmask;
        addr_q[1]      <= p1_addr;
      end
    end
  end

  // Pending/busy flags: pending until granted, busy until the completion cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (cap[i]) begin
          pend[i]   <= 1'b1;
          busy_q[i] <= 1'b1;
        end else begin
          if (grant_en && gnt[i]) begin
            pend[i] <= 1'b0;
          end
          if (done_n && (nxt_port == 1'(i))) begin
            busy_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic: grant, lane walk, busy handshake and timeout.
  always_comb begin
    state_n   = state;
    lane_n    = lane;
    tmr_n     = tmr;
    err_n     = err_flag;
    grant_en  = 1'b0;
    cap_rdata = 1'b0;
    pick      = '0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          grant_en = 1'b1;
          err_n    = 1'b0;
          tmr_n    = '0;
          if (req_sel.op == OP_RD) begin
            lane_n  = '0;
            state_n = ISSUE;
          end else begin
            pick = lowest_lane(req_sel.wmask);
            if (pick.valid) begin
              lane_n  = pick.lane;
              state_n = ISSUE;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      ISSUE: begin
        if (ram_busy) begin
          state_n = DRAIN;
        end else begin
          tmr_n = (tmr == TMR_MAX) ? tmr : tmr + 1'b1;
          if (tmr_n == TMR_MAX) begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      DRAIN: begin
        if (!ram_busy) begin
          if (req_sel.op == OP_RD) begin
            cap_rdata = 1'b1;
            state_n   = DONE;
          end else begin
            pick = lowest_lane(req_sel.wmask & lanes_above(lane));
            if (pick.valid) begin
              lane_n  = pick.lane;
              tmr_n   = '0;
              state_n = ISSUE;
            end else begin
              state_n = DONE;
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sequencer datapath and registered controller/port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= 1'b0;
      lane      <= '0;
      tmr       <= '0;
      err_flag  <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < int'(PORTS); i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      cur      <= nxt_port;
      lane     <= lane_n;
      tmr      <= tmr_n;
      err_flag <= err_n;
      ram_rd   <= issue_n && (req_sel.op == OP_RD);
      ram_wr   <= issue_n && (req_sel.op == OP_WR);
      if (issue_n) begin
        ram_addr  <= RAM_ADDR_W'({addr_sel, lane_n});
        ram_wdata <= (req_sel.op == OP_WR) ? req_sel.wdata[{lane_n, 3'b000} +: BYTE_W] : '0;
      end
      for (int i = 0; i < int'(PORTS); i++) begin
        ack_q[i] <= done_n && (nxt_port == 1'(i));
        err_q[i] <= done_n && (nxt_port == 1'(i)) && err_n;
        if (cap_rdata && (cur == 1'(i))) begin
          rdata_q[i] <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_spiram_port_arbiter.sv
// Scoreboard bench for spiram_port_arbiter with a small SPI controller model.
module tb_spiram_port_arbiter;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned TIMEOUT = 64;

  logic              clk;
  logic              reset;
  logic              p0_rd, p0_wr, p1_rd, p1_wr;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic [3:0]        p0_wmask, p1_wmask;
  logic              p0_busy, p0_ack, p0_err, p1_busy, p1_ack, p1_err;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              ram_rd, ram_wr;
  logic [15:0]       ram_addr;
  logic [7:0]        ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_rbusy, ram_wbusy;

  spiram_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p0_busy(p0_busy), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p1_busy(p1_busy), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_rbusy(ram_rbusy), .ram_wbusy(ram_wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ram_exp_t;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        is_rd;
    logic [31:0] rdata;
  } ack_exp_t;

  ram_exp_t ram_q[$];
  ack_exp_t ack_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller model: busy for 3 cycles after accepting a strobe, unless told not to respond.
  logic [1:0]  mcnt;
  logic        mrd;
  logic        respond;
  logic [31:0] rd_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 2'd0;
      mrd  <= 1'b0;
    end else if (mcnt != 2'd0) begin
      mcnt <= mcnt - 2'd1;
    end else if ((ram_rd || ram_wr) && respond) begin
      mcnt <= 2'd3;
      mrd  <= ram_rd;
    end
  end

  assign ram_rbusy = (mcnt != 2'd0) && mrd;
  assign ram_wbusy = (mcnt != 2'd0) && !mrd;
  assign ram_rdata = rd_val;

  // Monitors: each strobe rise is one SPI transaction; each ack is one completion.
  logic prev_stb = 1'b0;
  int   hi_len   = 0;
  int   last_len = 0;

  always @(negedge clk) begin : mon
    ram_exp_t    e;
    ack_exp_t    a;
    logic [1:0]  av;
    logic [1:0]  ev;
    logic [31:0] rsel;
    if ((ram_rd || ram_wr) && !prev_stb) begin
      if (ram_q.size() == 0) begin
        check("ram_unexpected", 64'({ram_rd, ram_wr, ram_addr, ram_wdata}), 64'(0));
      end else begin
        e = ram_q.pop_front();
        check("ram_txn", 64'({ram_rd, ram_wr, ram_addr, ram_wr ? ram_wdata : 8'h00}),
              64'({!e.wr, e.wr, e.addr, e.wr ? e.data : 8'h00}));
      end
    end
    if (ram_rd || ram_wr) begin
      hi_len++;
    end else if (prev_stb) begin
      last_len = hi_len;
      hi_len   = 0;
    end
    prev_stb = ram_rd || ram_wr;

    if (p0_ack || p1_ack) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 64'({p1_ack, p0_ack}), 64'(0));
      end else begin
        a    = ack_q.pop_front();
        av   = a.port ? 2'b10 : 2'b01;
        ev   = a.err ? av : 2'b00;
        rsel = a.port ? p1_rdata : p0_rdata;
        check("ack", 64'({p1_ack, p0_ack, p1_err, p0_err, a.port ? p1_busy : p0_busy,
                          (a.is_rd && !a.err) ? rsel : 32'h0}),
              64'({av, ev, 1'b0, (a.is_rd && !a.err) ? a.rdata : 32'h0}));
      end
    end
  end

  task automatic exp_ram(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    ram_exp_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    ram_q.push_back(e);
  endtask

  task automatic exp_ack(input logic port, input logic err, input logic is_rd, input logic [31:0] rdata);
    ack_exp_t a;
    a.port = port; a.err = err; a.is_rd = is_rd; a.rdata = rdata;
    ack_q.push_back(a);
  endtask

  task automatic set_req(input logic port, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
    if (port) begin
      p1_rd = rd; p1_wr = wr; p1_addr = a; p1_wdata = wd; p1_wmask = wm;
    end else begin
      p0_rd = rd; p0_wr = wr; p0_addr = a; p0_wdata = wd; p0_wmask = wm;
    end
  endtask

  task automatic clear_reqs();
    p0_rd = 1'b0; p0_wr = 1'b0; p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  // Bounded wait for the scoreboard to empty and both ports to go idle.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((ram_q.size() != 0 || ack_q.size() != 0 || p0_busy || p1_busy) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(tag, 64'(ram_q.size() + ack_q.size()) + 64'(p0_busy) + 64'(p1_busy), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k;
    reset   = 1'b1;
    respond = 1'b1;
    rd_val  = 32'hDEADBEEF;
    clear_reqs();
    p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
    p1_addr = '0; p1_wdata = '0; p1_wmask = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", 64'({p0_busy, p0_ack, p0_err, p1_busy, p1_ack, p1_err, ram_rd, ram_wr, ram_addr, ram_wdata}), 64'(0));
    check("rst_rdata", {p0_rdata, p1_rdata}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single read on port 0.
    exp_ram(1'b0, 16'h0048, 8'h00);
    exp_ack(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    set_req(1'b0, 1'b1, 1'b0, 14'h0012, 32'h0, 4'h0);
    @(negedge clk); clear_reqs();
    wait_done("t1_done");

    // Masked write on port 1: lanes 1 and 3 only.
    exp_ram(1'b1, 16'h0005, 8'h22);
    exp_ram(1'b1, 16'h0007, 8'h44);
    exp_ack(1'b1, 1'b0, 1'b0, 32'h0);
    set_req(1'b1, 1'b0, 1'b1, 14'h0001, 32'h44332211, 4'b1010);
    @(negedge clk); clear_reqs();
    wait_done("t2_done");

    // Simultaneous reads after reset: port 0, port 1, then port 0 first again.
    do_reset();
    rd_val = 32'h12345678;
    exp_ram(1'b0, 16'h0040, 8'h00);
    exp_ram(1'b0, 16'h0080, 8'h00);
    exp_ack(1'b0, 1'b0, 1'b1, 32'h12345678);
    exp_ack(1'b1, 1'b0, 1'b1, 32'h12345678);
    set_req(1'b0, 1'b1, 1'b0, 14'h0010, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 14'h0020, 32'h0, 4'h0);
    @(negedge clk); clear_reqs();
    wait_done("t3a_done");
    exp_ram(1'b0, 16'h00C0, 8'h00);
    exp_ram(1'b0, 16'h00C4, 8'h00);
    exp_ack(1'b0, 1'b0, 1'b1, 32'h12345678);
    exp_ack(1'b1, 1'b0, 1'b1, 32'h12345678);
    set_req(1'b0, 1'b1, 1'b0, 14'h0030, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b1, 14'h0031, 32'hFFFFFFFF, 4'hF);
    @(negedge clk); clear_reqs();
    wait_done("t3b_done");

    // Empty write mask: no SPI traffic, ack two cycles after the request.
    exp_ack(1'b0, 1'b0, 1'b0, 32'h0);
    set_req(1'b0, 1'b0, 1'b1, 14'h0003, 32'hAABBCCDD, 4'b0000);
    @(negedge clk); clear_reqs();
    check("t4_busy", 64'(p0_busy), 64'(1));
    @(negedge clk);
    check("t4_ack_lat", 64'({p0_ack, p0_busy}), 64'(2'b10));
    @(negedge clk);
    check("t4_after", 64'({p0_ack, p0_busy}), 64'(0));
    wait_done("t4_done");

    // Controller never responds: strobe held TIMEOUT cycles, then ack+err.
    respond = 1'b0;
    exp_ram(1'b0, 16'h0014, 8'h00);
    exp_ack(1'b0, 1'b1, 1'b1, 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 14'h0005, 32'h0, 4'h0);
    @(negedge clk); clear_reqs();
    wait_done("t5_done");
    check("t5_rd_len", 64'(last_len), 64'(TIMEOUT));
    respond = 1'b1;
    rd_val  = 32'hCAFEF00D;
    exp_ram(1'b0, 16'h0018, 8'h00);
    exp_ack(1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    set_req(1'b0, 1'b1, 1'b0, 14'h0006, 32'h0, 4'h0);
    @(negedge clk); clear_reqs();
    wait_done("t5_recover");

    // Reset in DRAIN of a full-mask write.
    exp_ram(1'b1, 16'h0400, 8'hD4);
    set_req(1'b1, 1'b0, 1'b1, 14'h0100, 32'hA1B2C3D4, 4'b1111);
    @(negedge clk); clear_reqs();
    k = 0;
    while (!ram_wbusy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6_wbusy_seen", 64'(ram_wbusy), 64'(1));
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_async_outs", 64'({p0_busy, p0_ack, p0_err, p1_busy, p1_ack, p1_err, ram_rd, ram_wr, ram_addr, ram_wdata}), 64'(0));
    check("t6_async_rdata", {p0_rdata, p1_rdata}, 64'(0));
    check("t6_queue", 64'(ram_q.size()), 64'(0));
    ram_q.delete();
    ack_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle", 64'({p0_busy, p1_busy}), 64'(0));
    rd_val = 32'h0BADF00D;
    exp_ram(1'b0, 16'h001C, 8'h00);
    exp_ram(1'b1, 16'h0020, 8'h55);
    exp_ack(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    exp_ack(1'b1, 1'b0, 1'b0, 32'h0);
    set_req(1'b0, 1'b1, 1'b0, 14'h0007, 32'h0, 4'h0);
    set_req(1'b1, 1'b0, 1'b1, 14'h0008, 32'h00000055, 4'b0001);
    @(negedge clk); clear_reqs();
    wait_done("t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
